// File: rtl/parallel_alus_if.sv
// Operand/result bundle for the vector ALU stage.
// Master drives operands (issue side); slave is the ALU.
interface parallel_alus_if #(
   parameter int unsigned LANES  = 4,
   parameter int unsigned LANE_W = 32
);
   logic                      valid_in;
   logic [2:0]                op;
   logic [LANES*LANE_W-1:0]   a;
   logic [LANES*LANE_W-1:0]   b;
   logic [LANES*LANE_W-1:0]   y;
   logic                      valid_out;
   logic [LANES-1:0]          carry;
   logic [LANES-1:0]          zero;

   modport master (
      output valid_in, op, a, b,
      input  y, valid_out, carry, zero
   );

   modport slave (
      input  valid_in, op, a, b,
      output y, valid_out, carry, zero
   );
endinterface

// File: rtl/parallel_alus.sv
// Vector ALU stage: one op applied to every 32-bit lane in parallel, result registered.
// Lanes are fully independent (no cross-lane carries); one result per cycle, latency 1.
module parallel_alus #(
   parameter int unsigned LANES  = 4,
   parameter int unsigned LANE_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   parallel_alus_if.slave bus
);
   localparam int unsigned DW = LANES * LANE_W;

   localparam logic [2:0] OpAdd   = 3'b000;
   localparam logic [2:0] OpSub   = 3'b001;
   localparam logic [2:0] OpAnd   = 3'b010;
   localparam logic [2:0] OpOr    = 3'b011;
   localparam logic [2:0] OpXor   = 3'b100;
   localparam logic [2:0] OpRotb  = 3'b101;
   localparam logic [2:0] OpXtime = 3'b110;
   localparam logic [2:0] OpPass  = 3'b111;

   logic [DW-1:0]    y_c, y_d, y_q;
   logic [LANES-1:0] carry_c, carry_d, carry_q;
   logic [LANES-1:0] zero_c, zero_d, zero_q;
   logic             valid_d, valid_q;

   // Per-lane combinational datapath.
   always_comb begin : lane_dp
      logic [LANE_W-1:0] la, lb, res;
      logic [LANE_W:0]   sum, diff;
      logic [7:0]        bt;
      logic              cy;
      y_c     = '0;
      carry_c = '0;
      zero_c  = '0;
      bt      = '0;
      for (int i = 0; i < LANES; i++) begin
         la   = bus.a[i*LANE_W +: LANE_W];
         lb   = bus.b[i*LANE_W +: LANE_W];
         sum  = {1'b0, la} + {1'b0, lb};
         // Top bit of the widened difference is the unsigned borrow (a < b).
         diff = {1'b0, la} - {1'b0, lb};
         res  = '0;
         cy   = 1'b0;
         case (bus.op)
            OpAdd: begin
               res = sum[LANE_W-1:0];
               cy  = sum[LANE_W];
            end
            OpSub: begin
               res = diff[LANE_W-1:0];
               cy  = diff[LANE_W];
            end
            OpAnd:  res = la & lb;
            OpOr:   res = la | lb;
            OpXor:  res = la ^ lb;
            OpRotb: res = {la[LANE_W-9:0], la[LANE_W-1:LANE_W-8]};
            OpXtime: begin
               // GF(2^8) doubling per byte, reduced by 0x11B.
               for (int j = 0; j < LANE_W / 8; j++) begin
                  bt = la[j*8 +: 8];
                  res[j*8 +: 8] = {bt[6:0], 1'b0} ^ (bt[7] ? 8'h1b : 8'h00);
               end
            end
            OpPass: res = la;
            default: res = la;
         endcase
         y_c[i*LANE_W +: LANE_W] = res;
         carry_c[i]              = cy;
         zero_c[i]               = (res == '0);
      end
   end

   // Capture a new result only when issued; otherwise hold data and drop valid.
   always_comb begin
      y_d     = y_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      valid_d = bus.valid_in;
      if (bus.valid_in) begin
         y_d     = y_c;
         carry_d = carry_c;
         zero_d  = zero_c;
      end
   end

   // Output register bank, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q     <= '0;
         carry_q <= '0;
         zero_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         y_q     <= y_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         valid_q <= valid_d;
      end
   end

   assign bus.y         = y_q;
   assign bus.carry     = carry_q;
   assign bus.zero      = zero_q;
   assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_parallel_alus.sv
// Scoreboard bench for parallel_alus: stimulus pushes expected outputs per cycle,
// a monitor pops and compares one cycle later.
module tb_parallel_alus;
   logic clk = 1'b0;
   logic rst = 1'b0;

   parallel_alus_if bus ();

   parallel_alus dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         vld;
      logic [127:0] y;
      logic [3:0]   c;
      logic [3:0]   z;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         mon_e;
   int           n_cmp  = 0;
   int           n_fail = 0;
   bit           mon_en = 1'b0;
   logic [127:0] last_y = '0;
   logic [3:0]   last_c = '0;
   logic [3:0]   last_z = '0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Monitor: sample well after the active edge.
   always @(posedge clk) begin
      #2;
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_empty: got output cycle want queued expectation");
         end else begin
            mon_e = exp_q.pop_front();
            chk("valid_out", {127'd0, bus.valid_out}, {127'd0, mon_e.vld});
            chk("y", bus.y, mon_e.y);
            chk("carry", {124'd0, bus.carry}, {124'd0, mon_e.c});
            chk("zero", {124'd0, bus.zero}, {124'd0, mon_e.z});
         end
      end
   end

   // One issue cycle; idle cycles expect the previous result held.
   task automatic step(input bit v, input logic [2:0] o, input logic [127:0] ai,
                       input logic [127:0] bi, input logic [127:0] ey,
                       input logic [3:0] ec, input logic [3:0] ez);
      exp_t e;
      @(negedge clk);
      bus.valid_in = v;
      bus.op       = o;
      bus.a        = ai;
      bus.b        = bi;
      if (v) begin
         last_y = ey;
         last_c = ec;
         last_z = ez;
      end
      e.vld = v;
      e.y   = last_y;
      e.c   = last_c;
      e.z   = last_z;
      exp_q.push_back(e);
      mon_en = 1'b1;
   endtask

   task automatic idle();
      step(1'b0, 3'b000, '0, '0, '0, 4'h0, 4'h0);
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         @(posedge clk);
         #3;
         if (exp_q.size() == 0) done = 1'b1;
      end
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
         exp_q.delete();
      end
      mon_en = 1'b0;
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_y"}, bus.y, '0);
      chk({nm, "_valid"}, {127'd0, bus.valid_out}, '0);
      chk({nm, "_carry"}, {124'd0, bus.carry}, '0);
      chk({nm, "_zero"}, {124'd0, bus.zero}, '0);
   endtask

   localparam logic [127:0] KeyCol = 128'h2b28ab8b7eaef78415d215eb16a68801;

   initial begin
      bus.valid_in = 1'b0;
      bus.op       = 3'b000;
      bus.a        = '0;
      bus.b        = '0;
      #1 rst = 1'b1;
      #1 chk_reset("reset_async");
      repeat (2) @(posedge clk);
      #1 chk_reset("reset_hold");
      @(negedge clk);
      rst = 1'b0;

      // ROTB, XOR, ADD, XTIME back-to-back
      step(1, 3'b101, KeyCol, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff,
           128'h28ab8b2baef7847ed215eb15a6880116, 4'b0000, 4'b0000);
      step(1, 3'b100, KeyCol, KeyCol, '0, 4'b0000, 4'b1111);
      step(1, 3'b000, 128'hffffffff_7eaef784_15d215eb_16a68801,
           128'h00000001_00000001_00000001_00000001,
           128'h00000000_7eaef785_15d215ec_16a68802, 4'b1000, 4'b1000);
      step(1, 3'b110, 128'h2b28ab8b_00000000_01020304_80ff1b40, '0,
           128'h56504d0d_00000000_02040608_1be53680, 4'b0000, 4'b0100);
      // SUB then PASS back-to-back, then a gap
      step(1, 3'b001, 128'h00000000_00000005_12345678_00000000,
           128'h00000000_00000003_12345678_00000001,
           128'h00000000_00000002_00000000_ffffffff, 4'b0001, 4'b1010);
      step(1, 3'b111, 128'hdeadbeef_00000000_cafef00d_01234567,
           128'hffffffff_ffffffff_ffffffff_ffffffff,
           128'hdeadbeef_00000000_cafef00d_01234567, 4'b0000, 4'b0100);
      idle();
      // AND, OR, then ADD with multiple lane carries, then SUB followed by XOR
      step(1, 3'b010, 128'hf0f0f0f0_ffffffff_12345678_0000ffff,
           128'h0f0f0f0f_ffffffff_ff00ff00_ffff0000,
           128'h00000000_ffffffff_12005600_00000000, 4'b0000, 4'b1001);
      step(1, 3'b011, 128'hf0f0f0f0_ffffffff_12345678_0000ffff,
           128'h0f0f0f0f_ffffffff_ff00ff00_ffff0000,
           128'hffffffff_ffffffff_ff34ff78_ffffffff, 4'b0000, 4'b0000);
      idle();
      idle();
      step(1, 3'b000, 128'h80000000_ffffffff_00000001_7fffffff,
           128'h80000000_00000002_00000001_00000001,
           128'h00000000_00000001_00000002_80000000, 4'b1100, 4'b1000);
      step(1, 3'b001, 128'h00000001_00000000_00000010_ffffffff,
           128'h00000002_00000001_00000001_ffffffff,
           128'hffffffff_ffffffff_0000000f_00000000, 4'b1100, 4'b0001);
      step(1, 3'b100, 128'h00000001_00000000_00000010_ffffffff,
           128'h00000002_00000001_00000001_ffffffff,
           128'h00000003_00000001_00000011_00000000, 4'b0000, 4'b0001);
      idle();
      drain();

      // Reset mid-stream: issued op is discarded, no stale result afterwards
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.op       = 3'b111;
      bus.a        = KeyCol;
      #2 rst = 1'b1;
      #1 chk_reset("reset_midstream");
      @(posedge clk);
      #1 chk_reset("reset_hold_valid");
      @(negedge clk);
      bus.valid_in = 1'b0;
      rst = 1'b0;
      last_y = '0;
      last_c = '0;
      last_z = '0;
      idle();
      idle();
      step(1, 3'b111, KeyCol, '0, KeyCol, 4'b0000, 4'b0000);
      idle();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   // Global watchdog.
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end
endmodule
